// File: rtl/softmax_grad_stream.sv
// ============================================================================
// Module      : softmax_grad_stream
// Description : Streaming softmax backward pass. Takes NUM (y_i, g_i) beats,
//               buffers them and accumulates D = sum(y_j*g_j). It then emits
//               NUM beats of dx_i = y_i*(g_i - D), saturated to LEN bits.
//               The load and emit phases never overlap.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   high while loading (state LOAD)
//   in_y       y_i, unsigned Q2.14
//   in_g       g_i, signed, 14 fraction bits, LEN wide
//   out_valid  high while emitting (state EMIT)
//   out_ready  downstream accepts a beat
//   out_dx     dx_i, signed, 14 fraction bits, saturated, LEN wide
//   out_last   high on the beat carrying dx_{NUM-1}
//   busy       high unless idle in LOAD with cnt==0
// ============================================================================
`default_nettype none

module softmax_grad_stream #(
  parameter int NUM = 18,
  parameter int LEN = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [15:0]    in_y,
  input  logic [LEN-1:0] in_g,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] out_dx,
  output logic           out_last,
  output logic           busy
);

  localparam int LEVEL = $clog2(NUM);
  localparam int AW    = 16 + LEN + 1 + LEVEL;  // accumulator width
  localparam int PYG   = 16 + LEN + 1;          // y*g product width
  localparam int DW    = AW + 1;                // diff width
  localparam int PW    = DW + 17;               // y*diff product width

  localparam logic [LEVEL-1:0] LAST = LEVEL'(NUM - 1);

  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [LEVEL-1:0]      cnt, cnt_nxt;
  logic signed [AW-1:0]  acc, acc_nxt;

  // Vector buffer; entries are always written before they are read.
  logic [15:0]           y_mem [NUM];
  logic [LEN-1:0]        g_mem [NUM];

  logic                  accept;
  logic                  emit_hs;

  // --------------------------------------------------------------------------
  // Load-side product: y is unsigned, so it is zero-extended; the product is
  // exact in PYG bits.
  // --------------------------------------------------------------------------
  logic signed [PYG-1:0] y_ext;
  logic signed [PYG-1:0] g_ext;
  logic signed [PYG-1:0] yg;

  assign y_ext = {{(LEN + 1){1'b0}}, in_y};
  assign g_ext = {{17{in_g[LEN-1]}}, in_g};
  assign yg    = y_ext * g_ext;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign out_last  = (state == EMIT) && (cnt == LAST);
  assign busy      = !((state == LOAD) && (cnt == '0));
  assign accept    = in_valid && in_ready;
  assign emit_hs   = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    case (state)
      LOAD: begin
        if (accept) begin
          acc_nxt = acc + {{LEVEL{yg[PYG-1]}}, yg};
          if (cnt == LAST) begin
            state_nxt = EMIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + LEVEL'(1);
          end
        end
      end
      EMIT: begin
        if (emit_hs) begin
          if (cnt == LAST) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
            acc_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + LEVEL'(1);
          end
        end
      end
      default: begin
        state_nxt = LOAD;
        cnt_nxt   = '0;
        acc_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      y_mem[cnt] <= in_y;
      g_mem[cnt] <= in_g;
    end
  end

  // --------------------------------------------------------------------------
  // Emit datapath: purely combinational from buffer[cnt] and acc, so out_dx
  // holds automatically while the downstream stalls.
  // --------------------------------------------------------------------------
  logic [15:0]           y_rd;
  logic [LEN-1:0]        g_rd;
  logic signed [DW-1:0]  g_sh;
  logic signed [DW-1:0]  diff;
  logic signed [PW-1:0]  y_w;
  logic signed [PW-1:0]  d_w;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  shr;
  logic [PW-LEN:0]       top;

  assign y_rd = y_mem[cnt];
  assign g_rd = g_mem[cnt];
  assign g_sh = {{(DW - LEN - 14){g_rd[LEN-1]}}, g_rd, 14'b0};
  assign diff = g_sh - {acc[AW-1], acc};
  assign y_w  = {{(PW - 16){1'b0}}, y_rd};
  assign d_w  = {{17{diff[DW-1]}}, diff};
  assign prod = y_w * d_w;
  assign shr  = prod >>> 28;     // floor of prod / 2^28

  // In range exactly when every bit from LEN-1 upward matches the sign.
  assign top = shr[PW-1:LEN-1];

  always_comb begin
    out_dx = shr[LEN-1:0];
    if (!((&top) || !(|top))) begin
      out_dx = shr[PW-1] ? {1'b1, {(LEN - 1){1'b0}}} : {1'b0, {(LEN - 1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: doc/softmax_grad_stream.md
SOFTMAX_GRAD_STREAM -- requirements
Module: softmax_grad_stream

Interface
REQ-001 Parameter NUM, default 18, is the vector length; it SHALL support 2..512.
REQ-002 Parameter LEN, default 16, is the width of the gradient input and output.
REQ-003 Localparam LEVEL SHALL be $clog2(NUM).
REQ-004 Localparam AW SHALL be 16+LEN+1+LEVEL.
REQ-005 There SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  upstream beat valid.
REQ-009 in_ready  output  1  block accepts a beat.
REQ-010 in_y  input  16  softmax output y_i: unsigned, 2 integer bits and 14 fraction bits.
REQ-011 in_g  input  LEN  upstream gradient g_i: signed two's complement, 14 fraction bits.
REQ-012 out_valid  output  1  dx beat valid.
REQ-013 out_ready  input  1  downstream accepts a beat.
REQ-014 out_dx  output  LEN  dx_i: signed, 14 fraction bits, saturated.
REQ-015 out_last  output  1  high on the beat carrying dx_{NUM-1}.
REQ-016 busy  output  1  high whenever the block is not in LOAD with cnt==0.

Function
REQ-017 The block SHALL compute the softmax backward pass dx_i = y_i*(g_i - D), where D = sum over j of y_j*g_j.
REQ-018 The FSM SHALL have exactly two states, LOAD and EMIT; an index counter cnt SHALL range 0..NUM-1.
REQ-019 in_ready SHALL be 1 exactly when state==LOAD; out_valid SHALL be 1 exactly when state==EMIT.
REQ-020 On in_valid&&in_ready, the block SHALL store y and g into buffer entry cnt.
REQ-021 On the same accept, acc SHALL become acc + y*g, using a full-precision signed product (28 fraction bits) and an AW-bit accumulator that never overflows.
REQ-022 On an accept with cnt==NUM-1, state SHALL go to EMIT and cnt SHALL become 0; otherwise cnt SHALL increment.
REQ-023 In EMIT, out_dx SHALL be derived from buffer[cnt] and acc alone, and SHALL be stable while out_valid&&!out_ready.
REQ-024 The EMIT datapath SHALL form diff = (g_cnt<<14) - acc at full width, then prod = y_cnt*diff at full width.
REQ-025 The result SHALL be prod arithmetically shifted right by 28 (floor), then saturated to [-2^(LEN-1), 2^(LEN-1)-1].
REQ-026 out_last SHALL be 1 exactly when state==EMIT and cnt==NUM-1.
REQ-027 On out_valid&&out_ready, cnt SHALL advance.
REQ-028 On the handshake with cnt==NUM-1, state SHALL go to LOAD, cnt SHALL become 0 and acc SHALL become 0, all in the same edge.
REQ-029 Latency: the first out_valid SHALL assert in the cycle after the NUM-th input accept.
REQ-030 Throughput: the block SHALL accept NUM input beats, then emit NUM output beats, with no overlap between the two phases.
REQ-031 in_valid during EMIT SHALL be ignored; no state change SHALL occur.
REQ-032 Gaps in in_valid or in out_ready SHALL stall only the counter; no data SHALL be lost or duplicated.
REQ-033 The buffer SHALL need no reset; unwritten entries are never read.

Reset
REQ-034 While rst_n is low, outputs and state SHALL be: state=LOAD, cnt=0, acc=0, out_valid=0, out_last=0, busy=0, in_ready=1.
REQ-035 out_dx SHALL be don't-care while out_valid=0.
REQ-036 Reset asserted mid-LOAD or mid-EMIT SHALL discard the partial vector.
REQ-037 The first accept after reset release SHALL be treated as element 0.

Verification (NUM=4, LEN=16 instance)
REQ-038 Scenario 1: y=[0x1000 x4], g=[0x4000 x4], out_ready=1 -> D=1.0; out_dx=0x0000 x4; out_last on beat 3 only.
REQ-039 Scenario 2: y=[0x2000,0x2000,0,0], g=[0x4000,0,0,0] -> out_dx=[0x1000,0xF000,0x0000,0x0000].
REQ-040 Scenario 3: y=[0xFFFF,0,0,0], g=[0x7FFF,0,0,0] -> out_dx[0]=0x8000 (negative saturation), others 0x0000.
REQ-041 Scenario 4: Scenario 2 data with in_valid toggled every other cycle and out_ready low for 3 cycles at beat 1 -> identical out_dx sequence; out_dx held at 0xF000 while stalled; in_ready=0 throughout EMIT.
REQ-042 Scenario 5: rst_n pulsed low during EMIT beat 2, then Scenario 1 data sent -> out_valid=0 immediately on reset assertion; next vector outputs 0x0000 x4 with correct out_last.
REQ-043 Scenario 6: two back-to-back vectors (Scenario 2, then Scenario 1) -> second result is unaffected by the first, confirming acc is cleared at the last beat.
